// File: rtl/directory_coherence_sequencer.sv
// ---------------------------------------------------------------------------
// directory_coherence_sequencer
//
// Purpose:
//   Single client of the bookkeeping directory. Round-robin arbitrates MSI
//   upgrade requests from four L1 slots (slot = {core_id, cache_type}:
//   0=imem0, 1=dmem0, 2=imem1, 3=dmem1) and runs one directory transaction
//   per request: read the entry, downgrade conflicting peers one at a time
//   (command, wait for write-back ack, update the peer row), write the
//   requester row, then respond to the requester.
//
// Ports:
//   CLK, RST_N        clock, synchronous active-low reset
//   req_*             per-slot upgrade requests (valid/ready, idx, tag, state)
//   resp_*            one-hot completion handshake to the requester
//   dg_*              one-hot downgrade command to a peer plus target line/state
//   dg_ack_*          one-hot downgrade-finished handshake from the peer
//   dir_put_*         directory request {idx, write_valid, row, core_id, cache_type}
//   dir_get_*         directory read response (80-bit entry, slot k at
//                     [(3-k)*ROW_SIZE +: ROW_SIZE]); row = {msi[1:0], tag}
// ---------------------------------------------------------------------------
module directory_coherence_sequencer #(
   parameter int INDEX_WIDTH = 12,
   parameter int TAG_WIDTH   = 18
) (
   input  logic                                    CLK,
   input  logic                                    RST_N,
   input  logic [3:0]                              req_valid,
   output logic [3:0]                              req_ready,
   input  logic [4*INDEX_WIDTH-1:0]                req_idx,
   input  logic [4*TAG_WIDTH-1:0]                  req_tag,
   input  logic [7:0]                              req_state,
   output logic [3:0]                              resp_valid,
   input  logic [3:0]                              resp_ready,
   output logic [3:0]                              dg_valid,
   input  logic [3:0]                              dg_ready,
   output logic [INDEX_WIDTH-1:0]                  dg_idx,
   output logic [TAG_WIDTH-1:0]                    dg_tag,
   output logic [1:0]                              dg_state,
   input  logic [3:0]                              dg_ack_valid,
   output logic [3:0]                              dg_ack_ready,
   output logic                                    dir_put_valid,
   input  logic                                    dir_put_ready,
   output logic [INDEX_WIDTH+1+(2+TAG_WIDTH)+2-1:0] dir_put_request,
   output logic                                    dir_get_valid,
   input  logic                                    dir_get_ready,
   input  logic [4*(2+TAG_WIDTH)-1:0]              dir_get_response
);

   localparam int ROW_SIZE = 2 + TAG_WIDTH;

   localparam logic [1:0] MSI_I = 2'd0;
   localparam logic [1:0] MSI_S = 2'd1;
   localparam logic [1:0] MSI_M = 2'd2;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_SCAN,
      ST_DG_CMD,
      ST_DG_ACK,
      ST_DG_WR,
      ST_REQ_WR,
      ST_RESP
   } state_t;

   state_t                   state_q, state_d;
   logic [1:0]               rr_q, rr_d;
   logic [1:0]               slot_q, slot_d;
   logic [INDEX_WIDTH-1:0]   idx_q, idx_d;
   logic [TAG_WIDTH-1:0]     tag_q, tag_d;
   logic [1:0]               rstate_q, rstate_d;
   logic [4*ROW_SIZE-1:0]    entry_q, entry_d;
   logic [3:0]               mask_q, mask_d;
   logic [7:0]               target_q, target_d;

   logic [1:0]               grant;
   logic                     grant_found;
   logic [3:0]               scan_mask;
   logic [7:0]               scan_target;
   logic [ROW_SIZE-1:0]      peer_row;
   logic [1:0]               peer_msi;
   logic [TAG_WIDTH-1:0]     peer_tag;
   logic [1:0]               cur;
   logic [1:0]               cur_target;
   logic                     put_wv;
   logic [ROW_SIZE-1:0]      put_row;
   logic [1:0]               put_ids;

   // Round-robin pick: first valid slot at or after the rotating pointer.
   always_comb begin
      logic [1:0] s;
      grant       = 2'd0;
      grant_found = 1'b0;
      s           = 2'd0;
      for (int i = 0; i < 4; i++) begin
         s = rr_q + 2'(i);
         if (!grant_found && req_valid[s]) begin
            grant       = s;
            grant_found = 1'b1;
         end
      end
   end

   // Conflict scan over the latched entry. A peer only conflicts when it
   // holds the same tag in a readable state; illegal MSI code 3 counts as I.
   always_comb begin
      scan_mask   = 4'd0;
      scan_target = 8'd0;
      peer_row    = '0;
      peer_msi    = MSI_I;
      peer_tag    = '0;
      for (int p = 0; p < 4; p++) begin
         peer_row = entry_q[(3-p)*ROW_SIZE +: ROW_SIZE];
         peer_msi = peer_row[ROW_SIZE-1 -: 2];
         peer_tag = peer_row[TAG_WIDTH-1:0];
         if (2'(p) != slot_q && peer_tag == tag_q &&
             (peer_msi == MSI_S || peer_msi == MSI_M)) begin
            if (rstate_q == MSI_M) begin
               scan_mask[p]          = 1'b1;
               scan_target[2*p +: 2] = MSI_I;
            end else if (peer_msi == MSI_M) begin
               scan_mask[p]          = 1'b1;
               scan_target[2*p +: 2] = MSI_S;
            end
         end
      end
   end

   // The peer being downgraded is the lowest pending bit; the bit is only
   // cleared once its row write is accepted, so it stays stable across
   // DG_CMD, DG_ACK and DG_WR.
   always_comb begin
      cur = 2'd0;
      for (int p = 3; p >= 0; p--) begin
         if (mask_q[p]) begin
            cur = 2'(p);
         end
      end
      cur_target = target_q[{cur, 1'b0} +: 2];
   end

   // Next-state and output decode. dir_get_valid depends on state only,
   // because the directory derives its put_ready from get_valid.
   always_comb begin
      state_d       = state_q;
      rr_d          = rr_q;
      slot_d        = slot_q;
      idx_d         = idx_q;
      tag_d         = tag_q;
      rstate_d      = rstate_q;
      entry_d       = entry_q;
      mask_d        = mask_q;
      target_d      = target_q;
      req_ready     = 4'd0;
      resp_valid    = 4'd0;
      dg_valid      = 4'd0;
      dg_idx        = '0;
      dg_tag        = '0;
      dg_state      = 2'd0;
      dg_ack_ready  = 4'd0;
      dir_put_valid = 1'b0;
      dir_get_valid = 1'b0;
      put_wv        = 1'b0;
      put_row       = '0;
      put_ids       = slot_q;

      case (state_q)
         ST_IDLE: begin
            if (grant_found) begin
               req_ready = 4'b0001 << grant;
               slot_d    = grant;
               rr_d      = grant + 2'd1;
               for (int k = 0; k < 4; k++) begin
                  if (grant == 2'(k)) begin
                     idx_d    = req_idx[k*INDEX_WIDTH +: INDEX_WIDTH];
                     tag_d    = req_tag[k*TAG_WIDTH +: TAG_WIDTH];
                     rstate_d = req_state[2*k +: 2];
                  end
               end
               state_d = ST_RD_REQ;
            end
         end
         ST_RD_REQ: begin
            dir_put_valid = 1'b1;
            if (dir_put_ready) begin
               state_d = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            dir_get_valid = 1'b1;
            if (dir_get_ready) begin
               entry_d = dir_get_response;
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            mask_d   = scan_mask;
            target_d = scan_target;
            state_d  = (scan_mask != 4'd0) ? ST_DG_CMD : ST_REQ_WR;
         end
         ST_DG_CMD: begin
            dg_valid = 4'b0001 << cur;
            dg_idx   = idx_q;
            dg_tag   = tag_q;
            dg_state = cur_target;
            if (dg_ready[cur]) begin
               state_d = ST_DG_ACK;
            end
         end
         ST_DG_ACK: begin
            dg_ack_ready = 4'b0001 << cur;
            if (dg_ack_valid[cur]) begin
               state_d = ST_DG_WR;
            end
         end
         ST_DG_WR: begin
            dir_put_valid = 1'b1;
            put_wv        = 1'b1;
            put_row       = {cur_target, tag_q};
            put_ids       = cur;
            if (dir_put_ready) begin
               mask_d  = mask_q & ~(4'b0001 << cur);
               state_d = (mask_d != 4'd0) ? ST_DG_CMD : ST_REQ_WR;
            end
         end
         ST_REQ_WR: begin
            dir_put_valid = 1'b1;
            put_wv        = 1'b1;
            put_row       = {rstate_q, tag_q};
            if (dir_put_ready) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            resp_valid = 4'b0001 << slot_q;
            if (resp_ready[slot_q]) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      dir_put_request = {idx_q, put_wv, put_row, put_ids};
   end

   // State register. Reset abandons any in-flight transaction without
   // touching the directory.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         rr_q     <= 2'd0;
         slot_q   <= 2'd0;
         idx_q    <= '0;
         tag_q    <= '0;
         rstate_q <= 2'd0;
         entry_q  <= '0;
         mask_q   <= 4'd0;
         target_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         slot_q   <= slot_d;
         idx_q    <= idx_d;
         tag_q    <= tag_d;
         rstate_q <= rstate_d;
         entry_q  <= entry_d;
         mask_q   <= mask_d;
         target_q <= target_d;
      end
   end

endmodule
